// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single mock memory port.
// Instruction fetch (I) and load/store (D) share one access per cycle.
// D normally wins contention; a starvation counter guarantees I a slot
// after MAX_STARVE consecutive passed-over cycles. Read data is registered
// into a one-cycle response pulse per side.
module mem_arbiter #(
  parameter int MAX_STARVE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_sel,
  input  logic        d_wen,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] m_addr,
  output logic [1:0]  m_sel,
  output logic        m_wen,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [3:0] starve_cnt;
  logic       i_mis, d_mis, i_win;
  rsp_t       i_rsp, d_rsp;

  assign i_mis = |i_addr[1:0];

  // D misalignment: half on odd byte, word off a 4-byte boundary, reserved size
  always_comb begin
    d_mis = 1'b0;
    case (d_sel)
      2'd1:    d_mis = d_addr[0];
      2'd2:    d_mis = |d_addr[1:0];
      2'd3:    d_mis = 1'b1;
      default: d_mis = 1'b0;
    endcase
  end

  // I wins when alone or when it has waited its bounded share of cycles
  assign i_win = i_req & (~d_req | (starve_cnt == STARVE_MAX));
  assign i_gnt = ~rst & i_win;
  assign d_gnt = ~rst & d_req & ~i_win;

  // Drive the memory port from whichever side holds the grant
  always_comb begin
    m_addr  = '0;
    m_sel   = 2'd2;
    m_wen   = 1'b0;
    m_wdata = '0;
    if (i_gnt) begin
      m_addr = i_addr;
    end else if (d_gnt) begin
      m_addr  = d_addr;
      m_sel   = d_sel;
      m_wen   = d_wen & ~d_mis;
      m_wdata = d_wdata;
    end
  end

  // Count consecutive cycles in which a waiting fetch lost to D
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (i_gnt || !i_req)
      starve_cnt <= '0;
    else if (d_gnt && starve_cnt != STARVE_MAX)
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Capture the granted access into a one-cycle response; data/err hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rsp <= '0;
      d_rsp <= '0;
    end else begin
      i_rsp.vld <= i_gnt;
      d_rsp.vld <= d_gnt;
      if (i_gnt) begin
        i_rsp.err  <= i_mis;
        i_rsp.data <= i_mis ? 32'd0 : m_rdata;
      end
      if (d_gnt) begin
        d_rsp.err  <= d_mis;
        d_rsp.data <= (d_mis || d_wen) ? 32'd0 : m_rdata;
      end
    end
  end

  assign i_rvalid = i_rsp.vld;
  assign i_err    = i_rsp.err;
  assign i_rdata  = i_rsp.data;
  assign d_rvalid = d_rsp.vld;
  assign d_err    = d_rsp.err;
  assign d_rdata  = d_rsp.data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte-array mock memory on the port,
// a reference model of arbitration and memory contents, expected responses
// queued at grant time and popped by an independent monitor.
module tb_mem_arbiter;
  localparam int MAXS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_wen, d_gnt, d_rvalid, d_err;
  logic [1:0]  d_sel, m_sel;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_wen;

  mem_arbiter #(.MAX_STARVE(MAXS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_sel(d_sel), .d_wen(d_wen),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .m_addr(m_addr), .m_sel(m_sel), .m_wen(m_wen), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // mock memory, little-endian, 256 bytes, zero-extended combinational read
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ma;
  always_comb begin
    ma = m_addr[7:0];
    case (m_sel)
      2'd0:    m_rdata = {24'd0, mem[ma]};
      2'd1:    m_rdata = {16'd0, mem[ma + 8'd1], mem[ma]};
      default: m_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    endcase
  end
  always @(posedge clk) begin
    if (m_wen) begin
      mem[m_addr[7:0]] <= m_wdata[7:0];
      if (m_sel != 2'd0) mem[m_addr[7:0] + 8'd1] <= m_wdata[15:8];
      if (m_sel == 2'd2) begin
        mem[m_addr[7:0] + 8'd2] <= m_wdata[23:16];
        mem[m_addr[7:0] + 8'd3] <= m_wdata[31:24];
      end
    end
  end

  // reference model state
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int waited = 0;   // consecutive cycles a requesting fetch lost to D

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t iq[$], dq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [1:0] s);
    logic [7:0] b;
    b = a[7:0];
    case (s)
      2'd0:    return {24'd0, ref_mem[b]};
      2'd1:    return {16'd0, ref_mem[b + 8'd1], ref_mem[b]};
      default: return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
    endcase
  endfunction

  function automatic logic dmis(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
  endfunction

  // one cycle: drive at negedge, check combinational outputs, queue expectations
  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [31:0] da, input logic [1:0] ds,
                      input logic dw, input logic [31:0] dd,
                      output logic ig, output logic dg);
    logic eig, edg, mis;
    exp_t ei, ed;
    @(negedge clk);
    i_req = ir; i_addr = ia;
    d_req = dr; d_addr = da; d_sel = ds; d_wen = dw; d_wdata = dd;
    #1;
    eig = ir && (!dr || waited == MAXS);
    edg = dr && !eig;
    mis = dmis(da, ds);
    chk("i_gnt", 32'(i_gnt), 32'(eig));
    chk("d_gnt", 32'(d_gnt), 32'(edg));
    chk("m_wen", 32'(m_wen), 32'(edg && dw && !mis));
    if (eig) chk("m_addr_i", m_addr, ia);
    if (edg) chk("m_addr_d", m_addr, da);
    ei = '{v: eig, d: 32'd0, e: 1'b0};
    ed = '{v: edg, d: 32'd0, e: 1'b0};
    if (eig) begin
      ei.e = (ia[1:0] != 2'b00);
      ei.d = ei.e ? 32'd0 : ref_rd(ia, 2'd2);
    end
    if (edg) begin
      ed.e = mis;
      if (!mis && !dw) ed.d = ref_rd(da, ds);
      if (!mis && dw) begin
        ref_mem[da[7:0]] = dd[7:0];
        if (ds != 2'd0) ref_mem[da[7:0] + 8'd1] = dd[15:8];
        if (ds == 2'd2) begin
          ref_mem[da[7:0] + 8'd2] = dd[23:16];
          ref_mem[da[7:0] + 8'd3] = dd[31:24];
        end
      end
    end
    iq.push_back(ei);
    dq.push_back(ed);
    waited = (ir && !eig) ? ((waited < MAXS) ? waited + 1 : MAXS) : 0;
    ig = eig;
    dg = edg;
  endtask

  // monitor: each cycle's grant decision is answered one cycle later
  always @(negedge clk) begin
    exp_t e;
    if (iq.size() > 0) begin
      e = iq.pop_front();
      chk("i_rvalid", 32'(i_rvalid), 32'(e.v));
      if (e.v) begin
        chk("i_rdata", i_rdata, e.d);
        chk("i_err", 32'(i_err), 32'(e.e));
      end
    end
    if (dq.size() > 0) begin
      e = dq.pop_front();
      chk("d_rvalid", 32'(d_rvalid), 32'(e.v));
      if (e.v) begin
        chk("d_rdata", d_rdata, e.d);
        chk("d_err", 32'(d_err), 32'(e.e));
      end
    end
  end

  initial begin
    logic ig, dg, ir, dr, ip, dp, dw;
    logic [31:0] ia, da;
    logic [1:0] ds;
    logic [7:0] pat;
    int diff;

    rst = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_sel = 0; d_wen = 0; d_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_i_rvalid", 32'(i_rvalid), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_errs", 32'({i_err, d_err}), 0);
    rst = 1'b0;

    // reset mid-cycle during a granted load and a pending store
    step(0, 0, 1, 32'h0, 2'd2, 0, 0, ig, dg);
    #1;
    rst = 1'b1;
    d_req = 1; d_wen = 1; d_sel = 2'd2; d_addr = 32'h20; d_wdata = 32'hA5A5A5A5;
    #1;
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_i_gnt", 32'(i_gnt), 0);
    chk("rst_m_wen", 32'(m_wen), 0);
    iq.delete(); dq.delete(); waited = 0;
    @(negedge clk);
    rst = 1'b0; d_req = 0;
    #1;
    chk("post_rst_d_rvalid", 32'(d_rvalid), 0);
    chk("post_rst_i_rvalid", 32'(i_rvalid), 0);
    step(0, 0, 1, 32'h20, 2'd2, 0, 0, ig, dg);            // reset-cycle store must not land

    // single fetch
    step(0, 0, 1, 32'h4, 2'd2, 1, 32'hDEADBEEF, ig, dg);
    step(1, 32'h4, 0, 0, 2'd0, 0, 0, ig, dg);

    // sizes
    step(0, 0, 1, 32'h8, 2'd2, 1, 32'h11223344, ig, dg);
    step(0, 0, 1, 32'h9, 2'd0, 0, 0, ig, dg);              // 0x33
    step(0, 0, 1, 32'hA, 2'd1, 0, 0, ig, dg);              // 0x1122
    step(0, 0, 1, 32'hC, 2'd1, 1, 32'hFFFF_BEEF, ig, dg);  // half store, upper ignored
    step(0, 0, 1, 32'hC, 2'd2, 0, 0, ig, dg);

    // misalignment
    step(0, 0, 1, 32'h6, 2'd2, 1, 32'h55667788, ig, dg);
    step(0, 0, 1, 32'h4, 2'd2, 0, 0, ig, dg);              // still DEADBEEF
    step(0, 0, 1, 32'h4, 2'd3, 0, 0, ig, dg);
    step(0, 0, 1, 32'h5, 2'd1, 0, 0, ig, dg);
    step(1, 32'h2, 0, 0, 2'd0, 0, 0, ig, dg);

    // starvation: both held high
    step(0, 0, 0, 0, 2'd0, 0, 0, ig, dg);
    pat = '0;
    for (int k = 0; k < 8; k++) begin
      step(1, 32'h4, 1, 32'h8 + 32'(k % 2) * 4, 2'd2, 0, 0, ig, dg);
      pat[k] = i_gnt;
    end
    chk("starve_seq", 32'(pat), 32'h88);

    // contention on the same word: D store first, then I fetch sees it
    step(0, 0, 0, 0, 2'd0, 0, 0, ig, dg);
    step(1, 32'h10, 1, 32'h10, 2'd2, 1, 32'hCAFEF00D, ig, dg);
    step(1, 32'h10, 0, 0, 2'd0, 0, 0, ig, dg);

    // store-then-load same address back to back
    step(0, 0, 1, 32'h14, 2'd2, 1, 32'h0BADF00D, ig, dg);
    step(0, 0, 1, 32'h14, 2'd2, 0, 0, ig, dg);

    // randomized traffic, requests held until granted
    ip = 0; dp = 0;
    for (int n = 0; n < 500; n++) begin
      ir = ip ? 1'b1 : ($urandom_range(0, 2) != 0);
      dr = dp ? 1'b1 : ($urandom_range(0, 2) != 0);
      ia = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
      if ($urandom_range(0, 9) == 0) ia[1:0] = 2'($urandom_range(1, 3));
      ds = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      da = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) != 0) begin
        if (ds == 2'd1) da[0] = 1'b0;
        if (ds == 2'd2) da[1:0] = 2'b00;
      end
      dw = $urandom_range(0, 1) != 0;
      step(ir, ia, dr, da, ds, dw, $urandom, ig, dg);
      ip = ir && !ig;
      dp = dr && !dg;
    end

    repeat (3) step(0, 0, 0, 0, 2'd0, 0, 0, ig, dg);
    diff = 0;
    for (int b = 0; b < 256; b++) if (mem[b] !== ref_mem[b]) diff++;
    chk("mem_final_diff", 32'(diff), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single RV32I mock memory port between instruction fetch (I, read-only, word) and load/store (D, byte/half/word, read/write).
- Grants one requester per cycle and drives the memory port combinationally from the winner.
- Registers the read data into a one-cycle response pulse.
- Checks alignment and uses a starvation counter to bound fetch stalls under data priority.

Parameters:
- MAX_STARVE, 3: consecutive contended D grants after which I wins the next contended cycle; valid range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous reset, active-high
- i_req  input  1  fetch request; held until i_gnt
- i_addr  input  32  fetch byte address
- i_gnt  output  1  fetch granted this cycle (combinational)
- i_rvalid  output  1  fetch response valid; one-cycle pulse
- i_rdata  output  32  fetch data, valid with i_rvalid
- i_err  output  1  fetch misaligned, valid with i_rvalid
- d_req  input  1  data request; held until d_gnt
- d_addr  input  32  data byte address
- d_sel  input  2  size: 0 byte, 1 half, 2 word, 3 reserved
- d_wen  input  1  1 = store, 0 = load
- d_wdata  input  32  store data, low-aligned
- d_gnt  output  1  data granted this cycle (combinational)
- d_rvalid  output  1  data response valid; one-cycle pulse, issued for loads and stores
- d_rdata  output  32  load data, zero-extended by memory; 0 for stores and errors
- d_err  output  1  data misaligned or reserved size, valid with d_rvalid
- m_addr  output  32  memory address
- m_sel  output  2  memory size select
- m_wen  output  1  memory write enable
- m_wdata  output  32  memory write data
- m_rdata  input  32  memory combinational read data

Behaviour:
- Reset (async, rst=1): i_rvalid, d_rvalid, i_err, d_err = 0; i_rdata, d_rdata = 0; starve_cnt = 0.
- While rst=1, combinational outputs are forced: i_gnt = 0, d_gnt = 0, m_wen = 0. Reset mid-transaction drops any pending response; no write occurs in a reset cycle.
- Arbitration (combinational, rst=0):
  - Only one request: that requester is granted.
  - Both requesting: D wins unless starve_cnt == MAX_STARVE, in which case I wins.
  - Never both grants in the same cycle.
- starve_cnt (posedge):
  - Increments when i_req & d_gnt, saturating at MAX_STARVE.
  - Clears to 0 when i_gnt or !i_req.
  - Otherwise holds.
- Alignment:
  - D is misaligned if d_sel=1 & d_addr[0], or d_sel=2 & d_addr[1:0]!=0, or d_sel=3.
  - I is misaligned if i_addr[1:0]!=0.
  - A misaligned request is still granted and consumes its slot: m_wen forced 0, no memory write.
- Memory drive:
  - I granted: m_addr=i_addr, m_sel=2, m_wen=0, m_wdata=0.
  - D granted: m_addr=d_addr, m_sel=d_sel, m_wen=d_wen & !misaligned, m_wdata=d_wdata.
  - No grant: m_addr=0, m_sel=2, m_wen=0, m_wdata=0.
- Response (posedge after grant, latency 1):
  - Granted side's rvalid=1; other side's rvalid=0.
  - rdata = m_rdata for an aligned load or fetch, else 0.
  - err = misaligned flag.
  - rdata and err hold their values when rvalid=0.
- Back-to-back: a requester may hold req across cycles; each granted cycle yields exactly one response one cycle later. Throughput is 1 access per cycle total.
- Store-then-load to the same address in consecutive cycles returns the new data (write lands at the posedge before the load's read).
- A requester changing address or size without a grant is legal; only the granted-cycle values matter.

Test Plan:
- Reset check: assert rst mid-cycle with d_req=1, d_wen=1 -> m_wen=0, d_gnt=0 immediately; d_rvalid=0 and counters 0 after release.
- Single fetch: mem word @0x4 = 0xDEADBEEF, i_req with i_addr=0x4 -> i_gnt same cycle; next cycle i_rvalid=1, i_rdata=0xDEADBEEF, i_err=0.
- Store/load sizes:
  - d_sel=2 store 0x11223344 @0x8, then d_sel=0 load @0x9 -> d_rdata=0x00000033.
  - d_sel=1 load @0xA -> 0x00001122.
- Misalignment:
  - d_sel=2 store @0x6 -> m_wen=0; next cycle d_rvalid=1, d_err=1, d_rdata=0; word @0x4 unchanged.
  - d_sel=3 -> d_err=1.
  - i_addr=0x2 -> i_err=1.
- Starvation, MAX_STARVE=3: i_req and d_req held high continuously -> grant sequence D,D,D,I,D,D,D,I; i_rvalid pulses every 4th cycle.
- Simultaneous events: D store and I fetch of the same word contend -> D granted first; I fetch in the following cycle returns the stored value.
